// File: rtl/serial_byte_feeder.sv
// Parallel-to-serial front end: one-deep holding register behind a valid/ready
// intake, emitting each word as WIDTH consecutive shift_enable cycles.
module serial_byte_feeder #(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 1,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             data,
    output logic             shift_enable,
    output logic             frame_done,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [GW-1:0] LAST_GAP = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_valid;
    logic             w_hold_valid_next;
    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] w_sreg_next;
    logic [WIDTH-1:0] w_sreg_shifted;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_next;
    logic [GW-1:0]    r_gap_cnt;
    logic [GW-1:0]    w_gap_cnt_next;
    logic             r_data;
    logic             r_shift_enable;
    logic             r_frame_done;
    logic             w_frame_end;
    logic             w_accept;
    logic             w_next_bit;

    // in_ready looks only at the registered hold flag, so an accept and a drain
    // can never land on the same edge.
    assign in_ready = ~r_hold_valid & reset;
    assign w_accept = in_valid & in_ready;
    assign busy     = (r_state != IDLE) | r_hold_valid;

    assign data         = r_data;
    assign shift_enable = r_shift_enable;
    assign frame_done   = r_frame_done;

    assign w_sreg_shifted = MSB_FIRST ? {r_sreg[WIDTH-2:0], 1'b0} : {1'b0, r_sreg[WIDTH-1:1]};
    assign w_next_bit     = MSB_FIRST ? w_sreg_next[WIDTH-1] : w_sreg_next[0];

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        w_state_next      = r_state;
        w_sreg_next       = r_sreg;
        w_hold_valid_next = r_hold_valid;
        w_cnt_next        = r_cnt;
        w_gap_cnt_next    = r_gap_cnt;
        w_frame_end       = 1'b0;

        if (w_accept) begin
            w_hold_valid_next = 1'b1;
        end

        unique case (r_state)
            IDLE: begin
                if (r_hold_valid) begin
                    w_sreg_next       = r_hold;
                    w_hold_valid_next = 1'b0;
                    w_cnt_next        = '0;
                    w_state_next      = SHIFT;
                end
            end
            SHIFT: begin
                w_sreg_next = w_sreg_shifted;
                w_cnt_next  = r_cnt + 1'b1;
                if (r_cnt == LAST_BIT) begin
                    w_frame_end = 1'b1;
                    w_cnt_next  = '0;
                    if (GAP_CYCLES == 0 && r_hold_valid) begin
                        w_sreg_next       = r_hold;
                        w_hold_valid_next = 1'b0;
                    end else if (GAP_CYCLES > 0) begin
                        w_gap_cnt_next = '0;
                        w_state_next   = GAP;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            GAP: begin
                w_gap_cnt_next = r_gap_cnt + 1'b1;
                if (r_gap_cnt == LAST_GAP) begin
                    w_gap_cnt_next = '0;
                    if (r_hold_valid) begin
                        w_sreg_next       = r_hold;
                        w_hold_valid_next = 1'b0;
                        w_cnt_next        = '0;
                        w_state_next      = SHIFT;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Outputs are registered from next-state values so they line up with the
    // cycle in which the downstream register shifts.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_hold_valid   <= 1'b0;
            r_cnt          <= '0;
            r_gap_cnt      <= '0;
            r_data         <= 1'b0;
            r_shift_enable <= 1'b0;
            r_frame_done   <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_hold_valid   <= w_hold_valid_next;
            r_cnt          <= w_cnt_next;
            r_gap_cnt      <= w_gap_cnt_next;
            r_data         <= (w_state_next == SHIFT) & w_next_bit;
            r_shift_enable <= (w_state_next == SHIFT);
            r_frame_done   <= w_frame_end;
        end
    end

    // NOTE: data registers carry no reset; their contents are ignored until the
    // matching valid/state bit says they are live.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_hold <= in_data;
        end
        r_sreg <= w_sreg_next;
    end

endmodule

// File: tb/tb_serial_byte_feeder.sv
// Drives four feeder configurations from directed and random producers and
// compares every cycle against a frame-scheduling reference model.
module tb_serial_byte_feeder;
    localparam int N    = 4;
    localparam int RING = 64;
    localparam int P_W [0:N-1] = '{8, 8, 8, 5};
    localparam int P_G [0:N-1] = '{1, 0, 1, 3};
    localparam int P_M [0:N-1] = '{1, 1, 0, 1};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data      [N];
    logic       in_valid     [N];
    logic       in_ready     [N];
    logic       data         [N];
    logic       shift_enable [N];
    logic       frame_done   [N];
    logic       busy         [N];

    // Reference model: one holding slot and a per-cycle timeline of expected outputs.
    bit         m_hold_v [N];
    logic [7:0] m_hold_b [N];
    int         m_free   [N];
    bit         e_se     [N][RING];
    bit         e_d      [N][RING];
    bit         e_fd     [N][RING];
    logic [7:0] e_byte   [N][RING];
    logic [7:0] stored   [N];
    logic [7:0] dq       [N][8];
    int         dq_n     [N];
    bit         acc      [N];
    bit         rand_mode;
    int         cyc;
    int         n_checks;
    int         n_fail;

    always #5 clk = ~clk;

    serial_byte_feeder #(.WIDTH(8), .GAP_CYCLES(1), .MSB_FIRST(1'b1)) dut0 (
        .clk(clk), .reset(rst_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .data(data[0]), .shift_enable(shift_enable[0]),
        .frame_done(frame_done[0]), .busy(busy[0]));
    serial_byte_feeder #(.WIDTH(8), .GAP_CYCLES(0), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .reset(rst_n), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .data(data[1]), .shift_enable(shift_enable[1]),
        .frame_done(frame_done[1]), .busy(busy[1]));
    serial_byte_feeder #(.WIDTH(8), .GAP_CYCLES(1), .MSB_FIRST(1'b0)) dut2 (
        .clk(clk), .reset(rst_n), .in_data(in_data[2]), .in_valid(in_valid[2]),
        .in_ready(in_ready[2]), .data(data[2]), .shift_enable(shift_enable[2]),
        .frame_done(frame_done[2]), .busy(busy[2]));
    serial_byte_feeder #(.WIDTH(5), .GAP_CYCLES(3), .MSB_FIRST(1'b1)) dut3 (
        .clk(clk), .reset(rst_n), .in_data(in_data[3][4:0]), .in_valid(in_valid[3]),
        .in_ready(in_ready[3]), .data(data[3]), .shift_enable(shift_enable[3]),
        .frame_done(frame_done[3]), .busy(busy[3]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] width_mask(input int w);
        return 8'((1 << w) - 1);
    endfunction

    task automatic push_all(input logic [7:0] b);
        for (int i = 0; i < N; i++) begin
            dq[i][dq_n[i]] = b;
            dq_n[i]++;
        end
    endtask

    task automatic pop(input int i);
        for (int k = 0; k < 7; k++) dq[i][k] = dq[i][k+1];
        dq_n[i]--;
    endtask

    // Edge e: a held byte starts its frame as soon as the line is free; frame
    // occupies cycles e..e+W-1, frame_done lands at e+W, next start >= e+W+GAP.
    task automatic model_edge();
        for (int i = 0; i < N; i++) begin
            acc[i] = 1'b0;
            if (!rst_n) begin
                m_hold_v[i] = 1'b0;
                m_free[i]   = 0;
                dq_n[i]     = 0;
                for (int s = 0; s < RING; s++) begin
                    e_se[i][s] = 1'b0;
                    e_d[i][s]  = 1'b0;
                    e_fd[i][s] = 1'b0;
                end
            end else if (m_hold_v[i] && cyc >= m_free[i]) begin
                for (int k = 0; k < P_W[i]; k++) begin
                    e_se[i][(cyc + k) % RING] = 1'b1;
                    e_d[i][(cyc + k) % RING]  = (P_M[i] != 0) ? m_hold_b[i][P_W[i]-1-k] : m_hold_b[i][k];
                end
                e_fd[i][(cyc + P_W[i]) % RING]   = 1'b1;
                e_byte[i][(cyc + P_W[i]) % RING] = m_hold_b[i];
                m_free[i]   = cyc + P_W[i] + P_G[i];
                m_hold_v[i] = 1'b0;
            end else if (!m_hold_v[i] && in_valid[i]) begin
                m_hold_v[i] = 1'b1;
                m_hold_b[i] = in_data[i] & width_mask(P_W[i]);
                acc[i]      = 1'b1;
                if (!rand_mode && dq_n[i] > 0) pop(i);
            end
        end
    endtask

    task automatic check_cycle();
        int s;
        s = cyc % RING;
        for (int i = 0; i < N; i++) begin
            check($sformatf("c%0d i%0d shift_enable", cyc, i), 32'(shift_enable[i]), 32'(e_se[i][s]));
            check($sformatf("c%0d i%0d data", cyc, i), 32'(data[i]), 32'(e_d[i][s]));
            check($sformatf("c%0d i%0d frame_done", cyc, i), 32'(frame_done[i]), 32'(e_fd[i][s]));
            check($sformatf("c%0d i%0d busy", cyc, i), 32'(busy[i]),
                  32'(m_hold_v[i] || cyc < m_free[i]));
            check($sformatf("c%0d i%0d in_ready", cyc, i), 32'(in_ready[i]), 32'(!m_hold_v[i] && rst_n));
            if (e_fd[i][s]) begin
                check($sformatf("c%0d i%0d stored_data", cyc, i), 32'(stored[i] & width_mask(P_W[i])),
                      32'(e_byte[i][s]));
            end
            // Downstream consumer: shifts toward the end the first bit must finish at.
            if (shift_enable[i]) begin
                if (P_M[i] != 0) begin
                    stored[i] = ((stored[i] << 1) | 8'(data[i])) & width_mask(P_W[i]);
                end else begin
                    stored[i] = stored[i] >> 1;
                    stored[i][P_W[i]-1] = data[i];
                end
            end
            e_se[i][s] = 1'b0;
            e_d[i][s]  = 1'b0;
            e_fd[i][s] = 1'b0;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (rand_mode) begin
                in_valid[i] = ($urandom_range(0, 2) != 0);
                in_data[i]  = 8'($urandom);
            end else begin
                in_valid[i] = (dq_n[i] > 0);
                in_data[i]  = (dq_n[i] > 0) ? dq[i][0] : 8'($urandom);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_cycle();
        drive();
        cyc++;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        rand_mode = 1'b0;
        rst_n     = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_hold_v[i] = 1'b0;
            m_hold_b[i] = 8'h00;
            m_free[i]   = 0;
            dq_n[i]     = 0;
            stored[i]   = 8'h00;
            in_valid[i] = 1'b0;
            in_data[i]  = 8'h00;
            for (int s = 0; s < RING; s++) begin
                e_se[i][s]   = 1'b0;
                e_d[i][s]    = 1'b0;
                e_fd[i][s]   = 1'b0;
                e_byte[i][s] = 8'h00;
            end
        end

        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();

        push_all(8'hA5);
        drive();
        repeat (16) step();
        check("single A5 msb-first stored", 32'(stored[0]), 32'h0000_00A5);
        check("single A5 lsb-first stored", 32'(stored[2]), 32'h0000_00A5);
        check("single A5 idle busy", 32'(busy[0]), 32'h0);

        push_all(8'h3C);
        push_all(8'hC3);
        push_all(8'hFF);
        drive();
        repeat (40) step();

        push_all(8'h0F);
        push_all(8'hF0);
        drive();
        repeat (26) step();

        push_all(8'h01);
        drive();
        repeat (14) step();

        // Reset lands at the fourth edge after the first accept, with a byte held.
        push_all(8'hA5);
        push_all(8'h3C);
        drive();
        repeat (4) step();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (16) step();

        rand_mode = 1'b1;
        for (int r = 0; r < 3000; r++) begin
            step();
            rst_n = ($urandom_range(0, 499) != 0);
        end
        rst_n     = 1'b1;
        rand_mode = 1'b0;
        drive();
        repeat (20) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
